// File: rtl/word_reduce16_pkg.sv
// Shared types and constants for the word_reduce16 streaming reduction stage.
// Holds the reduction op codes and the FSM state encoding.
package word_reduce16_pkg;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/word_reduce16_op.sv
// Combinational bitwise combine of two words: OR, AND or XOR.
// Select code 11 folds onto OR.
module word_op16
  import word_reduce16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       op_i,
  output logic [WIDTH-1:0] y_o
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign y_o[gi] = (op_i == OP_AND) ? (a_i[gi] & b_i[gi]) :
                       (op_i == OP_XOR) ? (a_i[gi] ^ b_i[gi]) :
                                          (a_i[gi] | b_i[gi]);
    end
  endgenerate

endmodule

// File: rtl/word_reduce16.sv
// Streaming packet reduction: folds valid/ready words with OR/AND/XOR and presents
// one result with zero flag, saturating word count and overflow flag.
module word_reduce16
  import word_reduce16_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q;
  logic [WIDTH-1:0] acc_q, acc_d, op_res;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_zero_q;
  logic [CNT_W-1:0] out_count_q;
  logic             out_ovf_q;
  logic             accept;

  assign in_ready  = (state_q != ST_HOLD);
  assign out_valid = (state_q == ST_HOLD);
  assign accept    = in_valid & in_ready;

  assign out_data  = out_data_q;
  assign out_zero  = out_zero_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  word_op16 #(.WIDTH(WIDTH)) u_op (
    .a_i  (acc_q),
    .b_i  (in_data),
    .op_i (op_q),
    .y_o  (op_res)
  );

  // Value the accumulator takes if the current word is accepted; the output
  // registers capture this same value when the last word lands.
  always_comb begin
    acc_d   = op_res;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (state_q == ST_IDLE) begin
      acc_d   = in_data;
      count_d = CNT_W'(1);
      ovf_d   = 1'b0;
    end else if (count_q == CNT_MAX) begin
      ovf_d   = 1'b1;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      op_q        <= OP_OR;
      out_data_q  <= '0;
      out_zero_q  <= 1'b0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACC: begin
          if (accept) begin
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (state_q == ST_IDLE) op_q <= in_op;
            if (in_last) begin
              state_q     <= ST_HOLD;
              out_data_q  <= acc_d;
              out_zero_q  <= (acc_d == '0);
              out_count_q <= count_d;
              out_ovf_q   <= ovf_d;
            end else begin
              state_q <= ST_ACC;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_reduce16.sv
// Scoreboard bench for word_reduce16: two instances (CNT_W=8 and CNT_W=2) share the
// input stream so count saturation is exercised alongside the normal-width results.
module tb_word_reduce16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [1:0]  in_op = 2'b00;
  logic        out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, out_zero_a, out_ovf_a;
  logic [15:0] out_data_a;
  logic [7:0]  out_count_a;
  logic        in_ready_b, out_valid_b, out_zero_b, out_ovf_b;
  logic [15:0] out_data_b;
  logic [1:0]  out_count_b;

  typedef struct {
    logic [15:0] data;
    logic        zero;
    logic [7:0]  cnt8;
    logic        ovf8;
    logic [1:0]  cnt2;
    logic        ovf2;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [15:0] pkt_words[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  word_reduce16 #(.WIDTH(16), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_last(in_last), .in_op(in_op), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .out_zero(out_zero_a),
    .out_count(out_count_a), .out_ovf(out_ovf_a)
  );

  word_reduce16 #(.WIDTH(16), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_last(in_last), .in_op(in_op), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_zero(out_zero_b),
    .out_count(out_count_b), .out_ovf(out_ovf_b)
  );

  // Result monitor: inputs change just after posedge, so at negedge the handshake
  // about to happen on the next rising edge is already visible.
  always @(negedge clk) begin
    if (rst_n && out_valid_a && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got data=%h with empty scoreboard", out_data_a);
      end else begin
        mon_e = sb_q.pop_front();
        if ({out_data_a, out_zero_a, out_count_a, out_ovf_a} !==
            {mon_e.data, mon_e.zero, mon_e.cnt8, mon_e.ovf8}) begin
          errors++;
          $display("FAIL result_w8: got data=%h zero=%b cnt=%0d ovf=%b, want data=%h zero=%b cnt=%0d ovf=%b",
                   out_data_a, out_zero_a, out_count_a, out_ovf_a,
                   mon_e.data, mon_e.zero, mon_e.cnt8, mon_e.ovf8);
        end
        checks++;
        if ({out_valid_b, out_data_b, out_zero_b, out_count_b, out_ovf_b} !==
            {1'b1, mon_e.data, mon_e.zero, mon_e.cnt2, mon_e.ovf2}) begin
          errors++;
          $display("FAIL result_w2: got vld=%b data=%h zero=%b cnt=%0d ovf=%b, want vld=1 data=%h zero=%b cnt=%0d ovf=%b",
                   out_valid_b, out_data_b, out_zero_b, out_count_b, out_ovf_b,
                   mon_e.data, mon_e.zero, mon_e.cnt2, mon_e.ovf2);
        end
        $display("result: data=%h zero=%b cnt8=%0d ovf8=%b cnt2=%0d ovf2=%b",
                 out_data_a, out_zero_a, out_count_a, out_ovf_a, out_count_b, out_ovf_b);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [15:0] d, input logic last, input logic [1:0] op);
    logic done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_op    = op;
    for (int g = 0; g < 50 && !done; g++) begin
      done = in_ready_a;
      tick();
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: word %h not accepted, in_ready=%b, want 1", d, in_ready_a);
    end
  endtask

  task automatic send_packet(input logic [1:0] op_first, input logic [1:0] op_rest);
    exp_t        e;
    logic [15:0] acc;
    int          n;
    n   = pkt_words.size();
    acc = '0;
    for (int i = 0; i < n; i++) begin
      drive_word(pkt_words[i], (i == n - 1), (i == 0) ? op_first : op_rest);
      if (i == 0)                  acc = pkt_words[i];
      else if (op_first == 2'b01)  acc = acc & pkt_words[i];
      else if (op_first == 2'b10)  acc = acc ^ pkt_words[i];
      else                         acc = acc | pkt_words[i];
    end
    e.data = acc;
    e.zero = (acc == 16'h0000);
    e.cnt8 = 8'((n > 255) ? 255 : n);
    e.ovf8 = (n > 255);
    e.cnt2 = 2'((n > 3) ? 3 : n);
    e.ovf2 = (n > 3);
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    for (int g = 0; g < 30 && sb_q.size() != 0; g++) tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results pending, want 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({out_valid_a, out_data_a, out_count_a, out_zero_a, out_ovf_a, in_ready_a} !== {1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: vld=%b data=%h cnt=%0d zero=%b ovf=%b rdy=%b, want 0 0000 0 0 0 1",
               out_valid_a, out_data_a, out_count_a, out_zero_a, out_ovf_a, in_ready_a);
    end
    rst_n = 1'b1;
    tick();
    drive_word(16'h1111, 1'b0, 2'b00);
    drive_word(16'h2222, 1'b0, 2'b00);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid_a, in_ready_a} !== 2'b01) begin
      errors++;
      $display("FAIL reset_midpacket: vld=%b rdy=%b, want 0 1", out_valid_a, in_ready_a);
    end
    #1 rst_n = 1'b1;
    tick();
    out_ready = 1'b0;
    drive_word(16'hBEEF, 1'b1, 2'b00);
    checks++;
    if ({out_valid_a, out_data_a} !== {1'b1, 16'hBEEF}) begin
      errors++;
      $display("FAIL hold_before_reset: vld=%b data=%h, want 1 beef", out_valid_a, out_data_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid_a, out_data_a, out_count_a, in_ready_a} !== {1'b0, 16'h0, 8'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_midhold: vld=%b data=%h cnt=%0d rdy=%b, want 0 0000 0 1",
               out_valid_a, out_data_a, out_count_a, in_ready_a);
    end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    $display("reset: done");
  endtask

  task automatic test_or();
    pkt_words = '{16'h0001, 16'h0F00, 16'hA000};
    send_packet(2'b00, 2'b00);
    wait_drain("or");
    checks++;
    if ({out_valid_a, out_data_a, out_count_a} !== {1'b0, 16'hAF01, 8'd3}) begin
      errors++;
      $display("FAIL or_retain: vld=%b data=%h cnt=%0d, want 0 af01 3", out_valid_a, out_data_a, out_count_a);
    end
  endtask

  task automatic test_and();
    pkt_words = '{16'hFF0F, 16'h0FF0};
    send_packet(2'b01, 2'b01);
    wait_drain("and1");
    pkt_words = '{16'h00FF, 16'hFF00};
    send_packet(2'b01, 2'b01);
    wait_drain("and2");
    checks++;
    if ({out_data_a, out_zero_a} !== {16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL and_zero: data=%h zero=%b, want 0000 1", out_data_a, out_zero_a);
    end
  endtask

  task automatic test_xor_opchange();
    pkt_words = '{16'h1234, 16'h1234};
    send_packet(2'b10, 2'b00);
    wait_drain("xor");
    pkt_words = '{16'h00F0, 16'h0F0F};
    send_packet(2'b11, 2'b01);
    wait_drain("op11");
  endtask

  task automatic test_backpressure();
    exp_t e;
    out_ready = 1'b0;
    pkt_words = '{16'h00F0, 16'h0F00};
    send_packet(2'b00, 2'b00);
    in_valid = 1'b1;
    in_data  = 16'h5555;
    in_last  = 1'b1;
    in_op    = 2'b10;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({in_ready_a, out_valid_a, out_data_a, out_count_a} !== {1'b0, 1'b1, 16'h0FF0, 8'd2}) begin
        errors++;
        $display("FAIL bp_hold_c%0d: rdy=%b vld=%b data=%h cnt=%0d, want 0 1 0ff0 2",
                 c, in_ready_a, out_valid_a, out_data_a, out_count_a);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid_a, in_ready_a} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b, want 0 1", out_valid_a, in_ready_a);
    end
    e.data = 16'h5555; e.zero = 1'b0; e.cnt8 = 8'd1; e.ovf8 = 1'b0; e.cnt2 = 2'd1; e.ovf2 = 1'b0;
    sb_q.push_back(e);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid_a, out_data_a} !== {1'b1, 16'h5555}) begin
      errors++;
      $display("FAIL bp_next_accept: vld=%b data=%h, want 1 5555", out_valid_a, out_data_a);
    end
    wait_drain("bp");
  endtask

  task automatic test_saturation();
    pkt_words = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010};
    send_packet(2'b00, 2'b00);
    wait_drain("sat5");
    checks++;
    if ({out_count_b, out_ovf_b, out_count_a} !== {2'd3, 1'b1, 8'd5}) begin
      errors++;
      $display("FAIL sat_flags: cnt2=%0d ovf2=%b cnt8=%0d, want 3 1 5", out_count_b, out_ovf_b, out_count_a);
    end
    pkt_words = '{16'h8000};
    send_packet(2'b00, 2'b00);
    wait_drain("sat1");
  endtask

  initial begin
    test_reset();
    test_or();
    test_and();
    test_xor_opchange();
    test_backpressure();
    test_saturation();
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
